// File: rtl/pcie_phy_pkg.sv
// Shared symbol constants and types for the Gen1/Gen2 PCIe PHY transmit path.
// Used by the framer and by anything that decodes its symbol stream.
package pcie_phy_pkg;

    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;
    localparam logic [7:0] D_IDL = 8'h00;

    typedef enum logic [1:0] {
        PKT_TLP  = 2'b01,
        PKT_DLLP = 2'b10
    } pcie_pkt_type_e;

    typedef enum logic [1:0] {
        StIdle,
        StBody,
        StTail,
        StDrop
    } framer_state_e;

endpackage

// File: rtl/pcie_phy_tx_framer.sv
// 8b/10b-era transmit framer: wraps TLPs in STP..END/EDB and DLLPs in SDP..END,
// emitting 4-symbol words with per-lane K flags and logical idle between packets.
module pcie_phy_tx_framer
    import pcie_phy_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_sym_data_o,
    output logic [KEEP_WIDTH-1:0] m_sym_datak_o,
    output logic                  m_sym_valid_o,
    input  logic                  m_sym_ready_i,
    input  logic                  link_up_i,
    output logic [15:0]           tlp_count_o,
    output logic [15:0]           dllp_count_o,
    output logic                  frame_err_o
);

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("pcie_phy_tx_framer: only DATA_WIDTH=32 is supported");
    end

    function automatic logic [2:0] popcount_keep(input logic [KEEP_WIDTH-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) n = n + {2'b00, v[i]};
        return n;
    endfunction

    framer_state_e r_state, w_state_d;
    logic [31:0]   r_data, w_data_d, r_tail_data, w_tail_data_d;
    logic [3:0]    r_datak, w_datak_d, r_tail_datak, w_tail_datak_d;
    logic          r_valid, w_valid_d;
    logic [7:0]    r_carry, w_carry_d;
    logic          r_nullify, w_nullify_d;
    logic [15:0]   r_tlp_cnt, r_dllp_cnt;
    logic          r_err, w_err;
    logic          w_tlp_inc, w_dllp_inc;

    logic          w_advance, w_accept, w_legal, w_lead_k, w_null, w_needs_tail;
    logic [1:0]    w_type;
    logic [2:0]    w_keep_cnt;
    logic [7:0]    w_lead, w_end_sym;
    logic [31:0]   w_word_data, w_tw_data;
    logic [3:0]    w_word_datak, w_tw_datak;

    assign w_advance  = !r_valid || m_sym_ready_i;
    assign w_type     = s_axis_tuser[1:0];
    assign w_legal    = (w_type == PKT_TLP) || (w_type == PKT_DLLP);
    assign w_keep_cnt = popcount_keep(s_axis_tkeep);
    assign w_lead_k   = (r_state == StIdle);
    // Lane 0 of every word is either the start symbol or the byte carried over from the last beat.
    assign w_lead     = !w_lead_k ? r_carry : ((w_type == PKT_DLLP) ? K_SDP : K_STP);
    assign w_null     = w_lead_k ? (s_axis_tuser[2] && (w_type == PKT_TLP)) : r_nullify;
    assign w_end_sym  = w_null ? K_EDB : K_END;
    assign w_needs_tail = s_axis_tlast && (w_keep_cnt >= 3'd3);

    always_comb begin
        s_axis_tready = 1'b0;
        unique case (r_state)
            StIdle:  s_axis_tready = w_advance && link_up_i;
            StBody:  s_axis_tready = w_advance;
            StDrop:  s_axis_tready = w_advance;
            default: s_axis_tready = 1'b0;
        endcase
    end
    assign w_accept = s_axis_tvalid && s_axis_tready;

    always_comb begin
        w_word_data  = {s_axis_tdata[23:0], w_lead};
        w_word_datak = {3'b000, w_lead_k};
        w_tw_data    = {D_IDL, D_IDL, D_IDL, w_end_sym};
        w_tw_datak   = 4'b0001;
        if (s_axis_tlast) begin
            unique case (w_keep_cnt)
                3'd0: begin
                    w_word_data  = {D_IDL, D_IDL, w_end_sym, w_lead};
                    w_word_datak = {2'b00, 1'b1, w_lead_k};
                end
                3'd1: begin
                    w_word_data  = {D_IDL, w_end_sym, s_axis_tdata[7:0], w_lead};
                    w_word_datak = {1'b0, 1'b1, 1'b0, w_lead_k};
                end
                3'd2: begin
                    w_word_data  = {w_end_sym, s_axis_tdata[15:0], w_lead};
                    w_word_datak = {1'b1, 2'b00, w_lead_k};
                end
                3'd4: begin
                    w_tw_data  = {D_IDL, D_IDL, w_end_sym, s_axis_tdata[31:24]};
                    w_tw_datak = 4'b0100;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= StIdle;
        else       r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        if (w_advance) begin
            unique case (r_state)
                StIdle: if (w_accept) begin
                    if (!w_legal)          w_state_d = s_axis_tlast ? StIdle : StDrop;
                    else if (!s_axis_tlast) w_state_d = StBody;
                    else                   w_state_d = w_needs_tail ? StTail : StIdle;
                end
                StBody: begin
                    if (!link_up_i)        w_state_d = (w_accept && s_axis_tlast) ? StIdle : StDrop;
                    else if (w_accept && s_axis_tlast) w_state_d = w_needs_tail ? StTail : StIdle;
                end
                StTail: w_state_d = StIdle;
                StDrop: if (w_accept && s_axis_tlast) w_state_d = StIdle;
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        w_data_d       = r_data;
        w_datak_d      = r_datak;
        w_valid_d      = r_valid;
        w_carry_d      = r_carry;
        w_nullify_d    = r_nullify;
        w_tail_data_d  = r_tail_data;
        w_tail_datak_d = r_tail_datak;
        w_err          = 1'b0;
        w_tlp_inc      = 1'b0;
        w_dllp_inc     = 1'b0;
        if (w_advance) begin
            w_data_d  = '0;
            w_datak_d = '0;
            w_valid_d = link_up_i;
            unique case (r_state)
                StIdle, StBody: begin
                    if (r_state == StBody && !link_up_i) begin
                        w_data_d  = {D_IDL, D_IDL, D_IDL, K_EDB};
                        w_datak_d = 4'b0001;
                        w_valid_d = 1'b1;
                        w_err     = 1'b1;
                    end else if (w_accept && (r_state == StBody || w_legal)) begin
                        w_data_d       = w_word_data;
                        w_datak_d      = w_word_datak;
                        w_valid_d      = 1'b1;
                        w_carry_d      = s_axis_tdata[31:24];
                        w_nullify_d    = w_null;
                        w_tail_data_d  = w_tw_data;
                        w_tail_datak_d = w_tw_datak;
                        w_tlp_inc      = (r_state == StIdle) && (w_type == PKT_TLP);
                        w_dllp_inc     = (r_state == StIdle) && (w_type == PKT_DLLP);
                    end else if (w_accept) begin
                        w_err = 1'b1;
                    end else if (r_state == StBody) begin
                        w_valid_d = 1'b0;
                    end
                end
                StTail: begin
                    w_valid_d = 1'b1;
                    if (!link_up_i) begin
                        w_data_d  = {D_IDL, D_IDL, D_IDL, K_EDB};
                        w_datak_d = 4'b0001;
                        w_err     = 1'b1;
                    end else begin
                        w_data_d  = r_tail_data;
                        w_datak_d = r_tail_datak;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data       <= '0;
            r_datak      <= '0;
            r_valid      <= 1'b0;
            r_carry      <= '0;
            r_nullify    <= 1'b0;
            r_tail_data  <= '0;
            r_tail_datak <= '0;
            r_tlp_cnt    <= '0;
            r_dllp_cnt   <= '0;
            r_err        <= 1'b0;
        end else begin
            r_data       <= w_data_d;
            r_datak      <= w_datak_d;
            r_valid      <= w_valid_d;
            r_carry      <= w_carry_d;
            r_nullify    <= w_nullify_d;
            r_tail_data  <= w_tail_data_d;
            r_tail_datak <= w_tail_datak_d;
            r_err        <= w_err;
            if (w_tlp_inc)  r_tlp_cnt  <= r_tlp_cnt + 16'd1;
            if (w_dllp_inc) r_dllp_cnt <= r_dllp_cnt + 16'd1;
        end
    end

    assign m_sym_data_o  = r_data;
    assign m_sym_datak_o = r_datak;
    assign m_sym_valid_o = r_valid;
    assign tlp_count_o   = r_tlp_cnt;
    assign dllp_count_o  = r_dllp_cnt;
    assign frame_err_o   = r_err;

endmodule

// File: tb/tb_pcie_phy_tx_framer.sv
// Directed bench for pcie_phy_tx_framer: hand-computed symbol words for DLLP, TLP,
// nullified TLP, back-pressure, link loss, illegal type and mid-packet reset.
module tb_pcie_phy_tx_framer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic [2:0]  s_axis_tuser;
    logic        s_axis_tready;
    logic [31:0] m_sym_data_o;
    logic [3:0]  m_sym_datak_o;
    logic        m_sym_valid_o;
    logic        m_sym_ready_i;
    logic        link_up_i;
    logic [15:0] tlp_count_o;
    logic [15:0] dllp_count_o;
    logic        frame_err_o;

    logic        r_tog = 1'b0;
    logic        r_phase = 1'b0;
    int          n_total = 0;
    int          n_bad = 0;
    int          err_cnt = 0;
    logic [35:0] cap_q[$];
    logic [35:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    pcie_phy_tx_framer u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tready(s_axis_tready),
        .m_sym_data_o (m_sym_data_o),
        .m_sym_datak_o(m_sym_datak_o),
        .m_sym_valid_o(m_sym_valid_o),
        .m_sym_ready_i(m_sym_ready_i),
        .link_up_i    (link_up_i),
        .tlp_count_o  (tlp_count_o),
        .dllp_count_o (dllp_count_o),
        .frame_err_o  (frame_err_o)
    );

    always @(posedge clk_i) begin
        #1;
        r_phase = ~r_phase;
    end
    assign m_sym_ready_i = r_tog ? r_phase : 1'b1;

    // Record every non-idle word that the sink actually takes at the next edge.
    always @(negedge clk_i) begin
        if (m_sym_valid_o && m_sym_ready_i && (m_sym_data_o != 32'h0 || m_sym_datak_o != 4'h0))
            cap_q.push_back({m_sym_datak_o, m_sym_data_o});
        if (frame_err_o) err_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input logic [2:0] u);
        bit done;
        done          = 1'b0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk_i);
            done = s_axis_tready;
            @(posedge clk_i);
            #1;
        end
        s_axis_tvalid = 1'b0;
        if (!done) check_eq("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic compare_words(input string tag);
        check_eq({tag, "_len"}, 64'(cap_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check_eq($sformatf("%s_w%0d", tag, i), 64'(cap_q[i]), 64'(exp_q[i]));
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic send_tlp16();
        send_beat(32'h24232221, 4'hF, 1'b0, 3'b001);
        send_beat(32'h28272625, 4'hF, 1'b0, 3'b001);
        send_beat(32'h2C2B2A29, 4'hF, 1'b0, 3'b001);
        send_beat(32'h302F2E2D, 4'hF, 1'b1, 3'b001);
    endtask

    task automatic expect_tlp16();
        exp_q.push_back({4'b0001, 32'h232221FB});
        exp_q.push_back({4'b0000, 32'h27262524});
        exp_q.push_back({4'b0000, 32'h2B2A2928});
        exp_q.push_back({4'b0000, 32'h2F2E2D2C});
        exp_q.push_back({4'b0100, 32'h0000FD30});
    endtask

    initial begin
        int e0;
        rst_i = 1'b1;
        link_up_i = 1'b0;
        s_axis_tdata = '0;
        s_axis_tkeep = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        s_axis_tuser = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_valid", 64'(m_sym_valid_o), 64'd0);
        check_eq("rst_data", 64'(m_sym_data_o), 64'd0);
        check_eq("rst_datak", 64'(m_sym_datak_o), 64'd0);
        check_eq("rst_tready", 64'(s_axis_tready), 64'd0);
        check_eq("rst_tlp_cnt", 64'(tlp_count_o), 64'd0);
        check_eq("rst_dllp_cnt", 64'(dllp_count_o), 64'd0);
        check_eq("rst_err", 64'(frame_err_o), 64'd0);

        rst_i = 1'b0;
        link_up_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("idle_valid", 64'(m_sym_valid_o), 64'd1);
        check_eq("idle_word", 64'({m_sym_datak_o, m_sym_data_o}), 64'd0);
        check_eq("idle_tready", 64'(s_axis_tready), 64'd1);
        cap_q.delete();

        // DLLP: 6 bytes in two beats -> exactly two words
        send_beat(32'h14131211, 4'hF, 1'b0, 3'b010);
        send_beat(32'hAAAA1615, 4'h3, 1'b1, 3'b010);
        repeat (5) @(posedge clk_i);
        #1;
        exp_q.push_back({4'b0001, 32'h1312115C});
        exp_q.push_back({4'b1000, 32'hFD161514});
        compare_words("dllp");
        check_eq("dllp_cnt", 64'(dllp_count_o), 64'd1);
        check_eq("dllp_tlp_cnt", 64'(tlp_count_o), 64'd0);

        // 16-byte TLP: four full beats, END lands in the TAIL word
        send_tlp16();
        repeat (5) @(posedge clk_i);
        #1;
        expect_tlp16();
        compare_words("tlp16");
        check_eq("tlp16_cnt", 64'(tlp_count_o), 64'd1);

        // 13-byte nullified TLP: EDB instead of END
        send_beat(32'h44434241, 4'hF, 1'b0, 3'b101);
        send_beat(32'h48474645, 4'hF, 1'b0, 3'b101);
        send_beat(32'h4C4B4A49, 4'hF, 1'b0, 3'b101);
        send_beat(32'h0000004D, 4'h1, 1'b1, 3'b101);
        repeat (5) @(posedge clk_i);
        #1;
        exp_q.push_back({4'b0001, 32'h434241FB});
        exp_q.push_back({4'b0000, 32'h47464544});
        exp_q.push_back({4'b0000, 32'h4B4A4948});
        exp_q.push_back({4'b0100, 32'h00FE4D4C});
        compare_words("tlp13n");
        check_eq("tlp13n_cnt", 64'(tlp_count_o), 64'd2);

        // Sink ready alternating: same word sequence expected
        r_tog = 1'b1;
        send_tlp16();
        repeat (12) @(posedge clk_i);
        r_tog = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        expect_tlp16();
        compare_words("tlp16_bp");
        check_eq("tlp16_bp_cnt", 64'(tlp_count_o), 64'd3);

        // Link loss after beat 2 of a 5-beat TLP
        e0 = err_cnt;
        send_beat(32'h54535251, 4'hF, 1'b0, 3'b001);
        send_beat(32'h58575655, 4'hF, 1'b0, 3'b001);
        link_up_i = 1'b0;
        send_beat(32'h5C5B5A59, 4'hF, 1'b0, 3'b001);
        send_beat(32'h605F5E5D, 4'hF, 1'b0, 3'b001);
        send_beat(32'h64636261, 4'hF, 1'b1, 3'b001);
        repeat (4) @(posedge clk_i);
        #1;
        exp_q.push_back({4'b0001, 32'h535251FB});
        exp_q.push_back({4'b0000, 32'h57565554});
        exp_q.push_back({4'b0001, 32'h000000FE});
        compare_words("linkdn");
        check_eq("linkdn_err", 64'(err_cnt - e0), 64'd1);
        check_eq("linkdn_valid", 64'(m_sym_valid_o), 64'd0);
        check_eq("linkdn_tready", 64'(s_axis_tready), 64'd0);
        check_eq("linkdn_tlp_cnt", 64'(tlp_count_o), 64'd4);
        link_up_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        cap_q.delete();

        // Illegal type: both beats dropped, idle continues
        e0 = err_cnt;
        send_beat(32'h74737271, 4'hF, 1'b0, 3'b011);
        send_beat(32'h78777675, 4'hF, 1'b1, 3'b011);
        repeat (4) @(posedge clk_i);
        #1;
        compare_words("badtype");
        check_eq("badtype_err", 64'(err_cnt - e0), 64'd1);
        check_eq("badtype_valid", 64'(m_sym_valid_o), 64'd1);
        check_eq("badtype_tlp_cnt", 64'(tlp_count_o), 64'd4);
        check_eq("badtype_dllp_cnt", 64'(dllp_count_o), 64'd1);

        // Reset mid-packet, then a clean DLLP with no stale carry
        send_beat(32'h84838281, 4'hF, 1'b0, 3'b001);
        rst_i = 1'b1;
        #1;
        check_eq("midrst_valid", 64'(m_sym_valid_o), 64'd0);
        check_eq("midrst_data", 64'(m_sym_data_o), 64'd0);
        check_eq("midrst_tlp_cnt", 64'(tlp_count_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        cap_q.delete();
        send_beat(32'h94939291, 4'hF, 1'b0, 3'b010);
        send_beat(32'h00009695, 4'h3, 1'b1, 3'b010);
        repeat (4) @(posedge clk_i);
        #1;
        exp_q.push_back({4'b0001, 32'h9392915C});
        exp_q.push_back({4'b1000, 32'hFD969594});
        compare_words("postrst");
        check_eq("postrst_dllp_cnt", 64'(dllp_count_o), 64'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
